gap_scheduler: RTL and testbench

GAP_SCHEDULER -- requirements
Module: gap_scheduler

---
 rtl/gap_pkg.sv | 7 +
 rtl/safe_alu.sv | 22 ++
 rtl/gap_scheduler.sv | 65 ++++++
 tb/tb_gap_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/gap_pkg.sv
// gap_pkg: shared FSM state type and width helper for the gap scheduler
package gap_pkg;
  typedef enum logic {eACCUM, eDRAIN} state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/safe_alu.sv
// safe_alu: saturating signed Qm.n multiply (truncated toward -inf) or add
module safe_alu #(
  parameter string OPERATION = "add",
  parameter int    WORD_SIZE = 16,
  parameter int    N_SIZE    = 8
) (
  input  logic signed [WORD_SIZE-1:0] a,
  input  logic signed [WORD_SIZE-1:0] b,
  output logic signed [WORD_SIZE-1:0] y
);
  localparam logic signed [2*WORD_SIZE-1:0] MAXV = {{(WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [2*WORD_SIZE-1:0] MINV = ~MAXV;
  logic signed [2*WORD_SIZE-1:0] aw, bw, r;
  assign aw = a;
  assign bw = b;
  if (OPERATION == "mult") begin : g_mult
    assign r = (aw * bw) >>> N_SIZE;
  end else begin : g_add
    assign r = aw + bw;
  end
  assign y = (r > MAXV) ? MAXV[WORD_SIZE-1:0] : (r < MINV) ? MINV[WORD_SIZE-1:0] : r[WORD_SIZE-1:0];
endmodule

// File: rtl/gap_scheduler.sv
// gap_scheduler: per-channel global average over INPUT_SIZE steps on one shared multiply-add
module gap_scheduler
  import gap_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int INPUT_SIZE   = 8,
  parameter int WORD_SIZE    = 16,
  parameter int N_SIZE       = 8,
  parameter int MULTIPLIER   = (2 ** N_SIZE) / INPUT_SIZE,
  localparam int CW = clog2_min1(NUM_CHANNELS),
  localparam int SW = clog2_min1(INPUT_SIZE)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [WORD_SIZE-1:0] data_r_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic signed [WORD_SIZE-1:0] data_r_o,
  output logic [CW-1:0]               chan_o
);
  state_e state_r, state_n;
  logic [CW-1:0] chan_r;
  logic [SW-1:0] step_r;
  logic signed [WORD_SIZE-1:0] acc_r [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] prod, sum;
  logic in_xfer, out_xfer, last_chan, last_step;
  assign ready_o   = (state_r == eACCUM);
  assign valid_o   = (state_r == eDRAIN);
  assign in_xfer   = valid_i && ready_o;
  assign out_xfer  = valid_o && ready_i;
  assign last_chan = (chan_r == CW'(NUM_CHANNELS - 1));
  assign last_step = (step_r == SW'(INPUT_SIZE - 1));
  assign data_r_o  = acc_r[chan_r];
  assign chan_o    = chan_r;
  safe_alu #(.OPERATION("mult"), .WORD_SIZE(WORD_SIZE), .N_SIZE(N_SIZE)) u_mult (
    .a(data_r_i), .b(WORD_SIZE'(MULTIPLIER)), .y(prod)
  );
  safe_alu #(.OPERATION("add"), .WORD_SIZE(WORD_SIZE), .N_SIZE(N_SIZE)) u_add (
    .a(acc_r[chan_r]), .b(prod), .y(sum)
  );
  always_comb begin
    state_n = (in_xfer && last_chan && last_step) ? eDRAIN :
              (out_xfer && last_chan) ? eACCUM : state_r;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eACCUM;
    else            state_r <= state_n;
  end
  // chan_r is shared: it walks channels while accumulating and again while draining
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      chan_r <= '0;
      step_r <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) acc_r[i] <= '0;
    end else if (in_xfer) begin
      acc_r[chan_r] <= (step_r == '0) ? prod : sum;
      chan_r        <= last_chan ? '0 : chan_r + 1'b1;
      if (last_chan) step_r <= last_step ? '0 : step_r + 1'b1;
    end else if (out_xfer) begin
      chan_r <= last_chan ? '0 : chan_r + 1'b1;
    end
  end
endmodule

// File: tb/tb_gap_scheduler.sv
// tb_gap_scheduler: random frames vs. an arithmetic averaging model, nominal and saturating scale
module tb_gap_scheduler;
  localparam int NC = 2, IS = 4, W = 16, N = 8, NW = NC * IS;
  localparam longint M_A = 64, M_B = 'h7FFF;
  logic clk = 0, reset_n = 0, valid_i = 0, ready_i = 0;
  logic signed [W-1:0] din = '0;
  logic rdy_a, vo_a, rdy_b, vo_b;
  logic signed [W-1:0] dout_a, dout_b;
  logic [0:0] ch_a, ch_b;
  int n_chk = 0, n_fail = 0;
  logic signed [W-1:0] words [NW];

  always #5 clk = ~clk;

  gap_scheduler #(.NUM_CHANNELS(NC), .INPUT_SIZE(IS), .WORD_SIZE(W), .N_SIZE(N), .MULTIPLIER(64)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .ready_o(rdy_a), .data_r_i(din),
    .valid_o(vo_a), .ready_i(ready_i), .data_r_o(dout_a), .chan_o(ch_a));
  gap_scheduler #(.NUM_CHANNELS(NC), .INPUT_SIZE(IS), .WORD_SIZE(W), .N_SIZE(N), .MULTIPLIER('h7FFF)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .ready_o(rdy_b), .data_r_i(din),
    .valid_o(vo_b), .ready_i(ready_i), .data_r_o(dout_b), .chan_o(ch_b));

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
  endfunction

  // average = sum over steps of floor(x*m/2^N), each term and running sum clipped
  function automatic longint model(input int ch, input longint m);
    longint acc = 0, p, q;
    for (int s = 0; s < IS; s++) begin
      p = longint'(words[s*NC+ch]) * m;
      q = p / 256;
      if (p < 0 && p % 256 != 0) q--;
      q = sat(q);
      acc = (s == 0) ? q : sat(acc + q);
    end
    return acc;
  endfunction

  task automatic chk_out(input int ch);
    check("drain_valid", 64'(vo_a), 64'd1);
    check("drain_ready", 64'(rdy_a), 64'd0);
    check("drain_chan", 64'(ch_a), 64'(ch));
    check("drain_data", 64'(dout_a), model(ch, M_A));
    check("sat_valid", 64'(vo_b), 64'd1);
    check("sat_chan", 64'(ch_b), 64'(ch));
    check("sat_data", 64'(dout_b), model(ch, M_B));
  endtask

  // Called at a negedge with the DUT idle in accumulate; returns at the negedge after the last drain
  task automatic run_frame(input int mode, input bit bubbles, input int bp_lo, input int bp_hi);
    int idx = 0, k;
    for (int i = 0; i < NW; i++) begin
      words[i] = (mode == 0) ? ((i % NC == 0) ? 16'sh0100 : 16'sh0200) :
                 (mode == 1) ? ((i % NC == 0) ? 16'shFF00 : W'($urandom)) :
                 (mode == 3) ? ((i % NC == 1) ? 16'sh7FFF : W'($urandom)) : W'($urandom);
    end
    while (idx < NW) begin
      check("acc_ready", 64'(rdy_a), 64'd1);
      check("acc_valid", 64'(vo_a), 64'd0);
      if (bubbles && $urandom_range(0, 2) == 0) valid_i = 0;
      else begin
        valid_i = 1;
        din = words[idx];
        idx++;
      end
      @(negedge clk);
    end
    valid_i = 0;
    for (int ch = 0; ch < NC; ch++) begin
      ready_i = 0;
      k = $urandom_range(bp_lo, bp_hi);
      repeat (k) begin
        chk_out(ch);
        @(negedge clk);
      end
      chk_out(ch);
      ready_i = 1;
      @(negedge clk);
    end
    ready_i = 0;
    check("post_ready", 64'(rdy_a), 64'd1);
    check("post_valid", 64'(vo_a), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(vo_a), 64'd0);
    check("rst_ready", 64'(rdy_a), 64'd1);
    reset_n = 1;
    @(negedge clk);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 3, 3);
    run_frame(1, 1, 0, 2);
    run_frame(3, 0, 0, 1);
    repeat (3) begin
      valid_i = 1;
      din = W'($urandom);
      @(negedge clk);
    end
    valid_i = 0;
    reset_n = 0;
    @(negedge clk);
    check("midrst_ready", 64'(rdy_a), 64'd1);
    check("midrst_valid", 64'(vo_a), 64'd0);
    reset_n = 1;
    @(negedge clk);
    run_frame(0, 0, 0, 0);
    run_frame(2, 0, 0, 0);
    run_frame(2, 0, 0, 0);
    repeat (12) run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
